// File: rtl/alu_regbank_exec_if.sv
// Register-file access bus: two combinational read ports, one write port and the store tap.
interface alu_regbank_exec_if;
  logic        escreve_reg;
  logic [3:0]  addra;
  logic [3:0]  addrb;
  logic [3:0]  addrc;
  logic [15:0] datac;
  logic [15:0] dataa;
  logic [15:0] datab;
  logic [15:0] store;

  modport master (
    output escreve_reg, addra, addrb, addrc, datac,
    input  dataa, datab, store
  );

  modport slave (
    input  escreve_reg, addra, addrb, addrc, datac,
    output dataa, datab, store
  );
endinterface

// File: rtl/alu_regbank_exec.sv
// Execute-stage datapath: 16x16 register bank with async clear, plus a stateless ALU and its control decode.
module alu_regbank_exec (
  input  logic                     clock,
  input  logic                     reset_n,
  alu_regbank_exec_if.slave        rf,
  input  logic [3:0]               state,
  input  logic [5:0]               chave,
  output logic [15:0]              valor,
  output logic [15:0]              lcd_r0,
  output logic [15:0]              lcd_r1,
  output logic [15:0]              lcd_r2,
  input  logic [1:0]               op_alu,
  input  logic [3:0]               opcode,
  input  logic [15:0]              operand_a,
  input  logic [15:0]              operand_b,
  output logic [15:0]              result,
  output logic                     overflow,
  output logic                     zero,
  output logic [3:0]               controle_alu
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1000;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  logic [15:0] regs [16];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
    end else if (rf.escreve_reg && (rf.addrc != 4'd0)) begin
      regs[rf.addrc] <= rf.datac;
    end
  end

  // Register 0 is forced to zero on read so it is valid even before the first reset.
  function automatic logic [15:0] rd(input logic [3:0] addr);
    return (addr == 4'd0) ? 16'h0000 : regs[addr];
  endfunction

  logic unused_chave;
  assign unused_chave = &{1'b0, chave[5:4]};

  assign rf.dataa = rd(rf.addra);
  assign rf.datab = rd(rf.addrb);
  assign rf.store = rd(rf.addrb);
  assign valor    = rd(chave[3:0]);
  assign lcd_r0   = regs[1];
  assign lcd_r1   = regs[2];
  assign lcd_r2   = regs[3];

  always_comb begin
    controle_alu = ALU_ADD;
    if (state == 4'b0000) begin
      controle_alu = ALU_ADD;
    end else begin
      case (op_alu)
        2'b01: controle_alu = ALU_SUB;
        2'b10: begin
          case (opcode)
            4'b0001: controle_alu = ALU_SUB;
            4'b0010: controle_alu = ALU_AND;
            4'b0011: controle_alu = ALU_OR;
            4'b0100: controle_alu = ALU_XOR;
            4'b0101: controle_alu = ALU_NOR;
            4'b0110: controle_alu = ALU_SLT;
            4'b0111: controle_alu = ALU_SLL;
            4'b1010: controle_alu = ALU_SRL;
            default: controle_alu = ALU_ADD;
          endcase
        end
        default: controle_alu = ALU_ADD;
      endcase
    end
  end

  logic [15:0] sum;
  logic [15:0] diff;
  assign sum  = operand_a + operand_b;
  assign diff = operand_a - operand_b;

  always_comb begin
    result   = 16'h0000;
    overflow = 1'b0;
    case (controle_alu)
      ALU_AND: result = operand_a & operand_b;
      ALU_OR:  result = operand_a | operand_b;
      ALU_ADD: begin
        result   = sum;
        overflow = (operand_a[15] == operand_b[15]) && (sum[15] != operand_a[15]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (operand_a[15] != operand_b[15]) && (diff[15] != operand_a[15]);
      end
      ALU_SLL: result = operand_a << operand_b[3:0];
      ALU_SRL: result = operand_a >> operand_b[3:0];
      ALU_SLT: result = ($signed(operand_a) < $signed(operand_b)) ? 16'h0001 : 16'h0000;
      ALU_XOR: result = operand_a ^ operand_b;
      ALU_NOR: result = ~(operand_a | operand_b);
      default: result = 16'h0000;
    endcase
  end

  assign zero = (result == 16'h0000);

endmodule

// File: tb/tb_alu_regbank_exec.sv
// Directed bench for alu_regbank_exec: register bank writes/reset behaviour and ALU decode/results.
module tb_alu_regbank_exec;

  logic        clock;
  logic        reset_n;
  logic [3:0]  state;
  logic [5:0]  chave;
  logic [15:0] valor;
  logic [15:0] lcd_r0, lcd_r1, lcd_r2;
  logic [1:0]  op_alu;
  logic [3:0]  opcode;
  logic [15:0] operand_a, operand_b;
  logic [15:0] result;
  logic        overflow;
  logic        zero;
  logic [3:0]  controle_alu;

  int total = 0;
  int bad   = 0;

  alu_regbank_exec_if rf ();

  alu_regbank_exec dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .rf           (rf.slave),
    .state        (state),
    .chave        (chave),
    .valor        (valor),
    .lcd_r0       (lcd_r0),
    .lcd_r1       (lcd_r1),
    .lcd_r2       (lcd_r2),
    .op_alu       (op_alu),
    .opcode       (opcode),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .result       (result),
    .overflow     (overflow),
    .zero         (zero),
    .controle_alu (controle_alu)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic alu(input logic [1:0] op, input logic [3:0] opc,
                     input logic [15:0] a, input logic [15:0] b);
    op_alu = op; opcode = opc; operand_a = a; operand_b = b;
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    state = 4'b0010; chave = 6'd0;
    op_alu = 2'b00; opcode = 4'd0; operand_a = 16'd0; operand_b = 16'd0;
    rf.escreve_reg = 1'b0; rf.addra = 4'd0; rf.addrb = 4'd0;
    rf.addrc = 4'd0; rf.datac = 16'd0;

    // Reset state
    @(posedge clock); #1;
    rf.addra = 4'd2; rf.addrb = 4'd3; chave = 6'd2; #1;
    chk("rst_dataa", rf.dataa, 16'h0000);
    chk("rst_store", rf.store, 16'h0000);
    chk("rst_lcd_r1", lcd_r1, 16'h0000);

    @(negedge clock);
    reset_n = 1'b1;

    // Write 0x1234 to r2; no bypass before the edge
    @(negedge clock);
    rf.escreve_reg = 1'b1; rf.addrc = 4'd2; rf.datac = 16'h1234; #1;
    chk("no_bypass", rf.dataa, 16'h0000);
    @(posedge clock); #1;
    chk("wr_lcd_r1", lcd_r1, 16'h1234);
    chk("wr_dataa", rf.dataa, 16'h1234);
    chk("wr_valor", valor, 16'h1234);

    // Write to r0 is ignored
    @(negedge clock);
    rf.addrc = 4'd0; rf.datac = 16'hFFFF; rf.addra = 4'd0;
    @(posedge clock); #1;
    chk("r0_zero", rf.dataa, 16'h0000);

    // r1 and r3, both ports on same register, store mirrors datab
    @(negedge clock);
    rf.addrc = 4'd1; rf.datac = 16'hA5A5;
    @(posedge clock); #1;
    @(negedge clock);
    rf.addrc = 4'd3; rf.datac = 16'h0F0F;
    @(posedge clock); #1;
    @(negedge clock);
    rf.escreve_reg = 1'b0; rf.addra = 4'd3; rf.addrb = 4'd3; #1;
    chk("same_a", rf.dataa, 16'h0F0F);
    chk("same_b", rf.datab, 16'h0F0F);
    chk("store_b", rf.store, 16'h0F0F);
    chk("lcd_r0", lcd_r0, 16'hA5A5);
    chk("lcd_r2", lcd_r2, 16'h0F0F);

    // Reset pulse mid-cycle clears everything without a clock edge
    #2;
    reset_n = 1'b0; #1;
    chk("async_lcd_r0", lcd_r0, 16'h0000);
    chk("async_lcd_r1", lcd_r1, 16'h0000);
    chk("async_lcd_r2", lcd_r2, 16'h0000);
    reset_n = 1'b1;

    // Reset held across a write edge wins, writes resume after release
    @(negedge clock);
    rf.escreve_reg = 1'b1; rf.addrc = 4'd5; rf.datac = 16'hBEEF; chave = 6'h35;
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("rst_blocks_wr", valor, 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("wr_resume", valor, 16'hBEEF);
    @(negedge clock);
    rf.escreve_reg = 1'b0;

    // ALU
    alu(2'b10, 4'b0000, 16'h7FFF, 16'h0001);
    chk("add_res", result, 16'h8000);
    chk("add_ovf", {15'd0, overflow}, 16'd1);
    chk("add_zero", {15'd0, zero}, 16'd0);

    alu(2'b01, 4'b0000, 16'h0005, 16'h0005);
    chk("sub_res", result, 16'h0000);
    chk("sub_zero", {15'd0, zero}, 16'd1);
    chk("sub_ovf", {15'd0, overflow}, 16'd0);

    alu(2'b01, 4'b0000, 16'h8000, 16'h0001);
    chk("sub_ovf_res", result, 16'h7FFF);
    chk("sub_ovf_flag", {15'd0, overflow}, 16'd1);

    alu(2'b10, 4'b0110, 16'hFFFF, 16'h0001);
    chk("slt_true", result, 16'h0001);
    chk("slt_ctl", {12'd0, controle_alu}, 16'h0007);
    alu(2'b10, 4'b0110, 16'h0001, 16'hFFFF);
    chk("slt_false", result, 16'h0000);
    chk("slt_zero", {15'd0, zero}, 16'd1);

    alu(2'b10, 4'b0111, 16'h0001, 16'h0004);
    chk("sll", result, 16'h0010);
    alu(2'b10, 4'b1010, 16'h8000, 16'h0013);
    chk("srl", result, 16'h1000);
    chk("srl_ctl", {12'd0, controle_alu}, 16'h0004);

    alu(2'b10, 4'b0010, 16'hF0F0, 16'h3C3C);
    chk("and", result, 16'h3030);
    alu(2'b10, 4'b0011, 16'hF0F0, 16'h3C3C);
    chk("or", result, 16'hFCFC);
    alu(2'b10, 4'b0100, 16'hF0F0, 16'h3C3C);
    chk("xor", result, 16'hCCCC);
    alu(2'b10, 4'b0101, 16'hF0F0, 16'h3C3C);
    chk("nor", result, 16'h0303);
    chk("nor_ctl", {12'd0, controle_alu}, 16'h000C);
    chk("nor_ovf", {15'd0, overflow}, 16'd0);

    alu(2'b10, 4'b1100, 16'h0003, 16'h0004);
    chk("undef_opc_add", result, 16'h0007);
    alu(2'b10, 4'b1011, 16'hFFFF, 16'h0001);
    chk("addi_wrap", result, 16'h0000);
    chk("addi_ovf", {15'd0, overflow}, 16'd0);
    alu(2'b11, 4'b0001, 16'h0002, 16'h0003);
    chk("op11_add", result, 16'h0005);
    alu(2'b00, 4'b0101, 16'h0010, 16'h0020);
    chk("op00_add", result, 16'h0030);

    state = 4'b0000;
    alu(2'b10, 4'b0001, 16'h0009, 16'h0001);
    chk("fetch_ctl", {12'd0, controle_alu}, 16'h0002);
    chk("fetch_res", result, 16'h000A);
    state = 4'b0010; #1;
    chk("exec_ctl", {12'd0, controle_alu}, 16'h0006);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_regbank_exec.md
ALU_REGBANK_EXEC -- requirements
Module: alu_regbank_exec

Interface
REQ-001 clock  in  1  single system clock; all register writes on its rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 state  in  4  current control-FSM state; 0000 = instruction fetch.
REQ-004 escreve_reg  in  1  register-file write enable.
REQ-005 addra, addrb  in  4 each  read addresses for ports A and B.
REQ-006 addrc  in  4  write address.
REQ-007 datac  in  16  write data.
REQ-008 dataa, datab  out  16 each  register read data for ports A and B.
REQ-009 store  out  16  store data to memory; always equal to datab.
REQ-010 chave  in  6  debug read select; only chave[3:0] is used.
REQ-011 valor  out  16  debug read data for register chave[3:0].
REQ-012 lcd_r0, lcd_r1, lcd_r2  out  16 each  live contents of registers 1, 2 and 3.
REQ-013 op_alu  in  2  ALU operation class.
REQ-014 opcode  in  4  instruction bits [15:12].
REQ-015 operand_a, operand_b  in  16 each  ALU operands.
REQ-016 result  out  16  ALU result.
REQ-017 overflow  out  1  signed overflow flag.
REQ-018 zero  out  1  result-is-zero flag.
REQ-019 controle_alu  out  4  decoded ALU function, exported for debug.

Function
REQ-020 The register file SHALL hold 16 registers of 16 bits; register 0 SHALL always read 0 and SHALL ignore writes.
REQ-021 A write SHALL occur at the rising edge of clock when escreve_reg=1 and addrc!=0: reg[addrc] <= datac.
REQ-022 All reads (dataa, datab, valor, lcd_r*) SHALL be combinational with no write bypass; the old value is returned until the write edge, and the new value immediately after it.
REQ-023 When both read ports address the same register, both SHALL return the same value.
REQ-024 ALU control decode SHALL be combinational and follow this priority:
  - state=0000 -> ADD, regardless of op_alu.
  - op_alu=00 -> ADD (address/PC computation).
  - op_alu=01 -> SUB (branch compare).
  - op_alu=10 -> decode by opcode.
  - op_alu=11 -> ADD.
REQ-025 Opcode decode (op_alu=10):
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOR, 0110 SLT.
  - 0111 SLL, 1010 SRL.
  - 1011 ADD (add-immediate).
  - all other opcodes -> ADD.
REQ-026 controle_alu encodings: AND=0000, OR=0001, ADD=0010, SLL=0011, SRL=0100, SUB=0110, SLT=0111, XOR=1000, NOR=1100; all unlisted codes SHALL produce result=0.
REQ-027 ADD/SUB SHALL wrap modulo 2^16 (two's complement).
REQ-028 SLT SHALL compare signed and return 0x0001 or 0x0000.
REQ-029 Shifts SHALL use operand_b[3:0] as the amount, applied to operand_a, zero-filled (SRL is logical).
REQ-030 overflow SHALL be asserted only for ADD/SUB signed overflow and SHALL be 0 for all other functions.
REQ-031 zero SHALL be 1 exactly when result==0x0000, for every function.
REQ-032 The ALU path SHALL be purely combinational, with zero cycles of latency from its inputs.

Reset
REQ-033 Asserting reset_n=0 SHALL immediately (asynchronously) clear all 16 registers to 0x0000, so dataa, datab, store, valor and lcd_r* read 0.
REQ-034 While reset_n=0, writes SHALL be blocked.
REQ-035 Writes SHALL resume at the first rising edge after reset_n returns to 1.
REQ-036 Reset asserted mid-write SHALL win: the register stays 0.
REQ-037 The ALU and ALU-control logic have no state and SHALL be unaffected by reset.

Verification
REQ-038 Reset, then escreve_reg=1, addrc=2, datac=0x1234, one clock edge -> lcd_r1=0x1234; addra=2 -> dataa=0x1234; valor with chave=2 -> 0x1234.
REQ-039 Write 0xFFFF to register 0 -> dataa with addra=0 reads 0x0000.
REQ-040 op_alu=10, opcode=0000, operands 0x7FFF + 0x0001 -> result=0x8000, overflow=1, zero=0.
REQ-041 op_alu=01, operands 0x0005 and 0x0005 -> result=0x0000, zero=1, overflow=0.
REQ-042 op_alu=10, opcode=0110, operand_a=0xFFFF (-1), operand_b=0x0001 -> result=0x0001; opcode=0111, operand_a=0x0001, operand_b=0x0004 -> result=0x0010.
REQ-043 state=0000 with op_alu=10 and opcode=0001 -> controle_alu=0010 (ADD); pulse reset_n low mid-cycle after writes -> all registers read 0 with no clock edge.
